// File: rtl/census5x5_if.sv
// Column-tap input and census-code output bundle
// for the 5x5 census transform stage.
interface census5x5_if #(
  parameter int DW = 8,
  parameter int XW = 11
);
  logic          col_valid;
  logic [DW-1:0] taps0;
  logic [DW-1:0] taps1;
  logic [DW-1:0] taps2;
  logic [DW-1:0] taps3;
  logic [DW-1:0] taps4;
  logic [23:0]   census_code;
  logic          census_valid;
  logic [XW-1:0] census_x;
  logic          row_done;

  modport master (
    output col_valid, taps0, taps1,
    output taps2, taps3, taps4,
    input  census_code, census_valid,
    input  census_x, row_done
  );

  modport slave (
    input  col_valid, taps0, taps1,
    input  taps2, taps3, taps4,
    output census_code, census_valid,
    output census_x, row_done
  );
endinterface

// File: rtl/census5x5_transform.sv
// 5x5 census transform: builds a sliding window from
// tap columns and emits one 24-bit code per interior pixel.
module census5x5_transform #(
  parameter int DW = 8,
  parameter int XW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clken,
  input  logic [XW-1:0] width,
  census5x5_if.slave    bus
);

  // window indexed [column][row], column 4 newest
  logic [4:0][4:0][DW-1:0] win_q, win_d;
  logic [XW-1:0] col_cnt_q, col_cnt_d;
  logic [XW-1:0] width_lat_q, width_lat_d;
  logic [2:0]    fill_cnt_q, fill_cnt_d;
  logic          s1_vld_q, s1_vld_d;
  logic [XW-1:0] s1_x_q, s1_x_d;
  logic          s1_last_q, s1_last_d;
  logic [23:0]   code_q, code_d;
  logic          valid_q, valid_d;
  logic [XW-1:0] x_q, x_d;
  logic          done_q, done_d;

  logic          push;
  logic [XW-1:0] wl;
  logic          last;
  logic [2:0]    fill_nx;
  logic [4:0][DW-1:0] tap_col;

  assign tap_col = {bus.taps4, bus.taps3,
                    bus.taps2, bus.taps1,
                    bus.taps0};

  // Row framing, window shift and S1 tag generation
  always_comb begin
    push = clken & bus.col_valid;
    if (col_cnt_q == '0) begin
      wl = (width == '0) ? XW'(1) : width;
    end else begin
      wl = width_lat_q;
    end
    last = (col_cnt_q == wl - XW'(1));
    fill_nx = (fill_cnt_q == 3'd5) ?
              3'd5 : fill_cnt_q + 3'd1;
    win_d       = win_q;
    col_cnt_d   = col_cnt_q;
    width_lat_d = width_lat_q;
    fill_cnt_d  = fill_cnt_q;
    s1_vld_d    = 1'b0;
    s1_x_d      = s1_x_q;
    s1_last_d   = 1'b0;
    if (push) begin
      for (int k = 0; k < 4; k++) begin
        win_d[k] = win_q[k+1];
      end
      win_d[4]    = tap_col;
      width_lat_d = wl;
      col_cnt_d   = last ? '0 : col_cnt_q + XW'(1);
      fill_cnt_d  = last ? 3'd0 : fill_nx;
      s1_vld_d    = (fill_nx == 3'd5);
      s1_x_d      = col_cnt_q - XW'(2);
      s1_last_d   = last;
    end
  end

  // S2: census compare of the current window
  always_comb begin
    code_d = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        if (r * 5 + c < 12) begin
          code_d[23 - (r * 5 + c)] =
            (win_q[c][r] < win_q[2][2]);
        end else if (r * 5 + c > 12) begin
          code_d[24 - (r * 5 + c)] =
            (win_q[c][r] < win_q[2][2]);
        end
      end
    end
    valid_d = s1_vld_q;
    x_d     = s1_x_q;
    done_d  = s1_vld_q & s1_last_q;
  end

  // State update, frozen by clken, cleared by rst
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q       <= '0;
      col_cnt_q   <= '0;
      width_lat_q <= '0;
      fill_cnt_q  <= '0;
      s1_vld_q    <= 1'b0;
      s1_x_q      <= '0;
      s1_last_q   <= 1'b0;
      code_q      <= '0;
      valid_q     <= 1'b0;
      x_q         <= '0;
      done_q      <= 1'b0;
    end else if (clken) begin
      win_q       <= win_d;
      col_cnt_q   <= col_cnt_d;
      width_lat_q <= width_lat_d;
      fill_cnt_q  <= fill_cnt_d;
      s1_vld_q    <= s1_vld_d;
      s1_x_q      <= s1_x_d;
      s1_last_q   <= s1_last_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      x_q         <= x_d;
      done_q      <= done_d;
    end
  end

  assign bus.census_code  = code_q;
  assign bus.census_valid = valid_q;
  assign bus.census_x     = x_q;
  assign bus.row_done     = done_q;

endmodule

// File: tb/tb_census5x5_transform.sv
// Scoreboard bench for census5x5_transform: a column
// model predicts codes, a monitor pops and compares them.
module tb_census5x5_transform;

  typedef logic [4:0][7:0] col_t;
  typedef struct {
    logic [23:0] code;
    int          x;
    bit          last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clken = 1'b0;
  logic [10:0] width = 11'd8;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  col_t hist[$];
  int   cidx = 0;

  logic [23:0] h_code;
  logic        h_valid;
  logic [10:0] h_x;
  logic        h_done;

  census5x5_if #(.DW(8), .XW(11)) bus();

  census5x5_transform #(.DW(8), .XW(11)) dut (
    .clk   (clk),
    .rst   (rst),
    .clken (clken),
    .width (width),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_push(input col_t c);
    int   effw;
    bit   last;
    exp_t e;
    logic [7:0] ctr;
    int   p;
    effw = (width == 0) ? 1 : int'(width);
    hist.push_back(c);
    if (hist.size() > 5) void'(hist.pop_front());
    last = (cidx == effw - 1);
    if (cidx >= 4 && hist.size() == 5) begin
      ctr = hist[2][2];
      e.code = '0;
      for (int r = 0; r < 5; r++) begin
        for (int k = 0; k < 5; k++) begin
          p = r * 5 + k;
          if (p < 12) e.code[23 - p] = hist[k][r] < ctr;
          if (p > 12) e.code[24 - p] = hist[k][r] < ctr;
        end
      end
      e.x = cidx - 2;
      e.last = last;
      sb.push_back(e);
    end
    if (last) begin
      cidx = 0;
      hist.delete();
    end else begin
      cidx++;
    end
  endtask

  task automatic drive(input bit en, input bit v,
                       input col_t c);
    @(negedge clk);
    clken = en;
    bus.col_valid = v;
    bus.taps0 = c[0];
    bus.taps1 = c[1];
    bus.taps2 = c[2];
    bus.taps3 = c[3];
    bus.taps4 = c[4];
    if (en && v) model_push(c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, '0);
  endtask

  task automatic push_gappy(input col_t c);
    bit en;
    bit v;
    for (int g = 0; g < 200; g++) begin
      en = ($urandom_range(0, 99) >= 30);
      v  = ($urandom_range(0, 99) >= 30);
      if (g == 199) begin
        en = 1'b1;
        v  = 1'b1;
      end
      drive(en, v, c);
      if (en && v) break;
    end
  endtask

  function automatic col_t rnd_col();
    col_t c;
    for (int r = 0; r < 5; r++) c[r] = 8'($urandom);
    return c;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_code"}, 64'(bus.census_code), 0);
    chk({tag, "_valid"}, 64'(bus.census_valid), 0);
    chk({tag, "_x"}, 64'(bus.census_x), 0);
    chk({tag, "_done"}, 64'(bus.row_done), 0);
  endtask

  // Output monitor: pops on enabled edges, checks hold
  // on frozen edges
  always @(posedge clk) begin
    bit e;
    bit r;
    exp_t ex;
    e = clken;
    r = rst;
    #1;
    if (!r && e) begin
      if (bus.census_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid",
              64'(bus.census_valid), 0);
        end else begin
          ex = sb.pop_front();
          chk("code", 64'(bus.census_code), 64'(ex.code));
          chk("x", 64'(bus.census_x), 64'(ex.x));
          chk("row_done", 64'(bus.row_done),
              64'(ex.last));
        end
      end else begin
        chk("done_idle", 64'(bus.row_done), 0);
      end
    end else if (!r && !e) begin
      chk("hold", {bus.census_code, bus.census_valid,
                   bus.census_x, bus.row_done},
          {h_code, h_valid, h_x, h_done});
    end
    h_code  = bus.census_code;
    h_valid = bus.census_valid;
    h_x     = bus.census_x;
    h_done  = bus.row_done;
  end

  initial begin
    col_t c;
    bus.col_valid = 1'b0;
    bus.taps0 = '0;
    bus.taps1 = '0;
    bus.taps2 = '0;
    bus.taps3 = '0;
    bus.taps4 = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // T1 flat row
    width = 11'd8;
    for (int i = 0; i < 8; i++) drive(1, 1, {5{8'h40}});
    idle(3);
    chk("t1_drain", 64'(sb.size()), 0);

    // T2 gradient, pixel = 10*col + row
    width = 11'd16;
    for (int k = 0; k < 16; k++) begin
      for (int r = 0; r < 5; r++) c[r] = 8'(10 * k + r);
      drive(1, 1, c);
    end
    idle(3);
    chk("t2_drain", 64'(sb.size()), 0);

    // T3 ties: 50 everywhere except two corners
    width = 11'd5;
    for (int k = 0; k < 5; k++) begin
      c = {5{8'd50}};
      if (k == 0) c[0] = 8'd49;
      if (k == 4) c[4] = 8'd51;
      drive(1, 1, c);
    end
    idle(3);
    chk("t3_drain", 64'(sb.size()), 0);

    // T4 random stalls and bubbles, 3 rows of 12
    width = 11'd12;
    for (int i = 0; i < 36; i++) push_gappy(rnd_col());
    idle(3);
    chk("t4_drain", 64'(sb.size()), 0);

    // T5 reset in the middle of a row
    width = 11'd10;
    for (int i = 0; i < 6; i++) drive(1, 1, rnd_col());
    idle(3);
    chk("t5_pre_drain", 64'(sb.size()), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("t5_reset");
    @(negedge clk);
    rst = 1'b0;
    cidx = 0;
    hist.delete();
    for (int i = 0; i < 10; i++) drive(1, 1, rnd_col());
    idle(3);
    chk("t5_drain", 64'(sb.size()), 0);

    // T6 boundary widths
    width = 11'd5;
    for (int i = 0; i < 10; i++) drive(1, 1, rnd_col());
    idle(3);
    chk("t6_w5_drain", 64'(sb.size()), 0);
    width = 11'd4;
    for (int i = 0; i < 12; i++) drive(1, 1, rnd_col());
    idle(3);
    chk("t6_w4_drain", 64'(sb.size()), 0);
    width = 11'd1920;
    for (int i = 0; i < 1920; i++) drive(1, 1, rnd_col());
    idle(3);
    chk("t6_w1920_drain", 64'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

endmodule
